// File: rtl/reg_cmd_pkg.sv
// -----------------------------------------------------------------------------
// reg_cmd_pkg
// Shared definitions for the register command decoder: register map widths,
// header field positions, payload length and the decoder state encoding.
// -----------------------------------------------------------------------------
package reg_cmd_pkg;

  // Register map geometry
  localparam int REGMAP_ADDR_WIDTH = 4;
  localparam int REGMAP_DATA_WIDTH = 32;

  // Header byte layout: [7] write/read, [6:4] reserved (must be 0), [3:0] address
  localparam int HDR_WRITE_BIT = 7;
  localparam int HDR_RSVD_MSB  = 6;
  localparam int HDR_RSVD_LSB  = 4;

  // Data bytes carried by a write frame or a read response
  localparam int PAYLOAD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_WR_STROBE,
    ST_RD_STROBE,
    ST_RD_CAPTURE,
    ST_TX_HDR,
    ST_TX_DATA
  } state_t;

  function automatic logic hdr_rsvd_ok(input logic [7:0] hdr);
    return hdr[HDR_RSVD_MSB:HDR_RSVD_LSB] == '0;
  endfunction

endpackage

// File: rtl/reg_cmd_tx_ser.sv
// -----------------------------------------------------------------------------
// reg_cmd_tx_ser
// Load-and-shift response serializer. A load pulse captures a frame (MSB byte
// first) and the number of bytes to send; bytes are then presented on the TX
// valid/ready stream one per accepted transfer.
//
// Ports
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_load          capture i_frame / i_nbytes this cycle
//   i_frame         frame to send, first byte in the top 8 bits
//   i_nbytes        number of bytes of i_frame to send (from the top)
//   o_tx_data       current response byte
//   o_tx_valid      o_tx_data valid
//   i_tx_ready      sink accepts byte
//   o_accept        a byte transfers this cycle
//   o_last          the byte currently presented is the final one
// -----------------------------------------------------------------------------
module reg_cmd_tx_ser #(
  parameter int NBYTES = 5,
  parameter int CNT_W  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic [8*NBYTES-1:0]   i_frame,
  input  logic [CNT_W-1:0]      i_nbytes,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_accept,
  output logic                  o_last
);

  logic [8*NBYTES-1:0] r_shift;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_valid;
  logic                w_accept;

  assign w_accept = r_valid & i_tx_ready;

  // The shift register only moves on an accepted transfer, so the presented
  // byte is stable for as long as the sink stalls.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_frame;
      r_cnt   <= i_nbytes;
      r_valid <= (i_nbytes != '0);
    end else if (w_accept) begin
      r_shift <= {r_shift[8*NBYTES-9:0], 8'h00};
      r_cnt   <= r_cnt - 1'b1;
      if (r_cnt == CNT_W'(1)) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_tx_data  = r_shift[8*NBYTES-1 -: 8];
  assign o_tx_valid = r_valid;
  assign o_accept   = w_accept;
  assign o_last     = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/reg_cmd_decoder.sv
// -----------------------------------------------------------------------------
// reg_cmd_decoder
// Byte-stream command decoder between the serial link and the register file.
// Parses read/write frames from the RX stream, issues one-cycle register
// strobes and returns an ack (write) or header + read data (read) on TX.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | waiting for a header byte; bad headers are dropped here
// WR_DATA     | collecting 4 write data bytes, MSB first; idle timer runs
// WR_STROBE   | reg_wr pulse; ack frame loaded into serializer
// RD_STROBE   | reg_rd pulse
// RD_CAPTURE  | reg_rdata valid; header + data loaded into serializer
// TX_HDR      | header echo being sent
// TX_DATA     | read data bytes being sent
//
// Ports
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_rx_data/valid, o_rx_ready received byte stream
//   o_tx_data/valid, i_tx_ready response byte stream
//   o_reg_addr, o_reg_wdata     register address / write data (held)
//   o_reg_wr, o_reg_rd          one-cycle write / read strobes
//   i_reg_rdata                 read data, valid the cycle after o_reg_rd
//   o_err_badhdr                pulse when a header is rejected
//   o_err_timeout               pulse when a write frame is abandoned
// -----------------------------------------------------------------------------
module reg_cmd_decoder
  import reg_cmd_pkg::*;
#(
  parameter int ADDR_W         = REGMAP_ADDR_WIDTH,
  parameter int DATA_W         = REGMAP_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [DATA_W-1:0] o_reg_wdata,
  output logic              o_reg_wr,
  output logic              o_reg_rd,
  input  logic [DATA_W-1:0] i_reg_rdata,
  output logic              o_err_badhdr,
  output logic              o_err_timeout
);

  localparam int NB    = PAYLOAD_BYTES + 1;
  localparam int CNT_W = $clog2(NB + 1);
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t              r_state, w_next;
  logic [7:0]          r_hdr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-9:0]   r_wbuf;
  logic [1:0]          r_bcnt;
  logic [TMR_W-1:0]    r_tmr;
  logic                r_err_badhdr;
  logic                r_err_timeout;

  logic                w_rx_ready;
  logic                w_rx_fire;
  logic                w_wr;
  logic                w_rd;
  logic                w_load;
  logic [8*NB-1:0]     w_frame;
  logic [CNT_W-1:0]    w_nbytes;
  logic                w_tx_accept;
  logic                w_tx_last;
  logic                w_last_byte;
  logic                w_tmr_expired;

  // Gated by reset so no byte is taken while reset is held.
  assign w_rx_ready = !i_reset && (r_state == ST_IDLE || r_state == ST_WR_DATA);
  assign w_rx_fire  = i_rx_valid & w_rx_ready;
  assign w_last_byte   = (r_bcnt == 2'(PAYLOAD_BYTES - 1));
  assign w_tmr_expired = (r_tmr == '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_wr     = 1'b0;
    w_rd     = 1'b0;
    w_load   = 1'b0;
    w_frame  = '0;
    w_nbytes = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_rx_fire && hdr_rsvd_ok(i_rx_data)) begin
          w_next = i_rx_data[HDR_WRITE_BIT] ? ST_WR_DATA : ST_RD_STROBE;
        end
      end
      ST_WR_DATA: begin
        if (w_rx_fire) begin
          if (w_last_byte) begin
            w_next = ST_WR_STROBE;
          end
        end else if (w_tmr_expired) begin
          w_next = ST_IDLE;
        end
      end
      ST_WR_STROBE: begin
        w_wr     = 1'b1;
        w_load   = 1'b1;
        w_frame  = {r_hdr, {DATA_W{1'b0}}};
        w_nbytes = CNT_W'(1);
        w_next   = ST_TX_HDR;
      end
      ST_RD_STROBE: begin
        w_rd   = 1'b1;
        w_next = ST_RD_CAPTURE;
      end
      ST_RD_CAPTURE: begin
        w_load   = 1'b1;
        w_frame  = {r_hdr, i_reg_rdata};
        w_nbytes = CNT_W'(NB);
        w_next   = ST_TX_HDR;
      end
      ST_TX_HDR: begin
        // A write ack is a single byte, so its header is also the last byte.
        if (w_tx_accept) begin
          w_next = w_tx_last ? ST_IDLE : ST_TX_DATA;
        end
      end
      ST_TX_DATA: begin
        if (w_tx_accept && w_tx_last) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Write data is assembled in a 3-byte buffer and only committed to r_wdata
  // with the 4th byte, so an abandoned frame never disturbs reg_wdata.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hdr         <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wbuf        <= '0;
      r_bcnt        <= '0;
      r_tmr         <= '0;
      r_err_badhdr  <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_badhdr  <= 1'b0;
      r_err_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rx_fire) begin
            if (!hdr_rsvd_ok(i_rx_data)) begin
              r_err_badhdr <= 1'b1;
            end else begin
              r_hdr  <= i_rx_data;
              r_bcnt <= '0;
              r_tmr  <= TMR_LOAD;
              if (!i_rx_data[HDR_WRITE_BIT]) begin
                r_addr <= i_rx_data[ADDR_W-1:0];
              end
            end
          end
        end
        ST_WR_DATA: begin
          if (w_rx_fire) begin
            r_wbuf <= {r_wbuf[DATA_W-17:0], i_rx_data};
            r_bcnt <= r_bcnt + 2'd1;
            r_tmr  <= TMR_LOAD;
            if (w_last_byte) begin
              r_addr  <= r_hdr[ADDR_W-1:0];
              r_wdata <= {r_wbuf, i_rx_data};
            end
          end else if (w_tmr_expired) begin
            r_err_timeout <= 1'b1;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  reg_cmd_tx_ser #(
    .NBYTES (NB),
    .CNT_W  (CNT_W)
  ) u_tx_ser (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_frame    (w_frame),
    .i_nbytes   (w_nbytes),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_accept   (w_tx_accept),
    .o_last     (w_tx_last)
  );

  assign o_rx_ready    = w_rx_ready;
  assign o_reg_addr    = r_addr;
  assign o_reg_wdata   = r_wdata;
  assign o_reg_wr      = w_wr;
  assign o_reg_rd      = w_rd;
  assign o_err_badhdr  = r_err_badhdr;
  assign o_err_timeout = r_err_timeout;

endmodule
